// File: rtl/fir_pkg.sv
// Shared types and helpers for the streaming FIR engine family.
// Values are treated as unsigned throughout.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

  // Widest intermediate the saturation helper handles.
  localparam int SAT_W = 64;

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Clamp an unsigned value to the largest number representable in dw bits.
  function automatic logic [SAT_W-1:0] sat_unsigned(input logic [SAT_W-1:0] value,
                                                    input int dw);
    logic [SAT_W-1:0] max_v;
    if (dw >= SAT_W) begin
      max_v = {SAT_W{1'b1}};
    end else begin
      max_v = (64'd1 << dw) - 64'd1;
    end
    if (value > max_v) begin
      return max_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate over one delay line, followed by the
// output scaling shift and saturation to DW bits.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 6,
  parameter int SHIFT = 8
) (
  input  logic [TAPS-1:0][DW-1:0] line,
  input  logic [TAPS-1:0][CW-1:0] coef,
  output logic [DW-1:0]           result
);

  localparam int ACC_W = acc_width(DW, CW, TAPS);

  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] shifted_s;
  logic [SAT_W-1:0] wide_s;

  // Sum of products across every tap; ACC_W leaves headroom so it never wraps
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_s = acc_s + ACC_W'(line[k]) * ACC_W'(coef[k]);
    end
  end

  // Scale down and clamp to the output range
  always_comb begin
    shifted_s = acc_s >> SHIFT;
    wide_s    = SAT_W'(shifted_s);
    result    = DW'(sat_unsigned(wide_s, DW));
  end

endmodule

// File: rtl/fir_stream_engine.sv
// Streaming multi-channel FIR engine: valid/ready in and out, run-time
// coefficients, packet/frame accounting and a running output average.
module fir_stream_engine
  import fir_pkg::*;
#(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int TAPS      = 6,
  parameter int CH        = 1,
  parameter int SHIFT     = 8,
  parameter int PKT_LEN   = 12,
  parameter int FRAME_LEN = 384,
  localparam int CHW      = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW       = $clog2(TAPS)
) (
  input  logic           clk,
  input  logic           Reset_n,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [CHW-1:0] in_ch,
  input  logic           coef_we,
  input  logic [AW-1:0]  coef_addr,
  input  logic [CW-1:0]  coef_data,
  output logic           coef_err,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_avg,
  output logic           packet_done,
  output logic           finish,
  output logic           busy
);

  localparam int PCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int FCW = $clog2(FRAME_LEN + 1);
  localparam logic [CHW:0] CH_LIM   = (CHW+1)'(CH);
  localparam logic [AW:0]  TAPS_LIM = (AW+1)'(TAPS);

  fir_state_e                      state_r;
  logic [CH-1:0][TAPS-1:0][DW-1:0] line_r;
  logic [TAPS-1:0][CW-1:0]         coef_r;
  logic [FCW-1:0]                  frame_cnt_r;
  logic [PCW-1:0]                  pkt_cnt_r;
  logic                            out_valid_r;
  logic                            packet_done_r;
  logic                            finish_r;
  logic                            busy_r;
  logic                            coef_err_r;
  logic [DW-1:0]                   out_data_r;
  logic [DW-1:0]                   out_avg_r;
  logic [CHW-1:0]                  out_ch_r;

  logic                    idle_or_done_s;
  logic                    in_ready_s;
  logic                    xfer_s;
  logic                    ch_ok_s;
  logic                    coef_apply_s;
  logic [TAPS-1:0][DW-1:0] sel_line_s;
  logic [TAPS-1:0][DW-1:0] next_line_s;
  logic [DW-1:0]           mac_s;
  logic [DW-1:0]           result_s;
  logic [DW:0]             avg_sum_s;
  logic [DW-1:0]           avg_next_s;

  // Handshake and write-acceptance decode
  always_comb begin
    idle_or_done_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    in_ready_s     = busy_r && (!out_valid_r || out_ready);
    xfer_s         = in_valid && in_ready_s;
    ch_ok_s        = {1'b0, in_ch} < CH_LIM;
    coef_apply_s   = coef_we && ({1'b0, coef_addr} < TAPS_LIM) && idle_or_done_s;
  end

  // Select the addressed channel's line and shift the new sample into tap 0
  always_comb begin
    sel_line_s = '0;
    for (int c = 0; c < CH; c++) begin
      sel_line_s = (in_ch == CHW'(c)) ? line_r[c] : sel_line_s;
    end
    next_line_s = (sel_line_s << DW) | {{((TAPS-1)*DW){1'b0}}, in_data};
  end

  fir_mac #(
    .DW    (DW),
    .CW    (CW),
    .TAPS  (TAPS),
    .SHIFT (SHIFT)
  ) u_mac (
    .line   (next_line_s),
    .coef   (coef_r),
    .result (mac_s)
  );

  // Out-of-range channels produce zero; running average at DW+1 bits
  always_comb begin
    result_s   = ch_ok_s ? mac_s : '0;
    avg_sum_s  = {1'b0, out_avg_r} + {1'b0, result_s};
    avg_next_s = DW'(avg_sum_s >> 1);
  end

  // Coefficient bank: writable only while no frame is running
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      coef_r     <= '0;
      coef_err_r <= 1'b0;
    end else begin
      coef_err_r <= coef_we && !coef_apply_s;
      if (coef_apply_s) begin
        coef_r[coef_addr] <= coef_data;
      end
    end
  end

  // Control FSM, counters, delay lines and the registered output stage
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      line_r        <= '0;
      frame_cnt_r   <= '0;
      pkt_cnt_r     <= '0;
      out_valid_r   <= 1'b0;
      packet_done_r <= 1'b0;
      finish_r      <= 1'b0;
      out_data_r    <= '0;
      out_ch_r      <= '0;
      out_avg_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // A pending result may still drain after the frame has closed
          if (out_valid_r && out_ready) begin
            out_valid_r   <= 1'b0;
            packet_done_r <= 1'b0;
          end
          if (start) begin
            state_r     <= ST_RUN;
            busy_r      <= 1'b1;
            frame_cnt_r <= '0;
            pkt_cnt_r   <= '0;
            line_r      <= '0;
            out_avg_r   <= '0;
            finish_r    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            for (int c = 0; c < CH; c++) begin
              if (in_ch == CHW'(c)) begin
                line_r[c] <= next_line_s;
              end
            end
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_ch_r    <= in_ch;
            out_avg_r   <= avg_next_s;
            frame_cnt_r <= frame_cnt_r + FCW'(1);
            if (pkt_cnt_r == PCW'(PKT_LEN - 1)) begin
              pkt_cnt_r     <= '0;
              packet_done_r <= 1'b1;
            end else begin
              pkt_cnt_r     <= pkt_cnt_r + PCW'(1);
              packet_done_r <= 1'b0;
            end
            if (frame_cnt_r == FCW'(FRAME_LEN - 1)) begin
              state_r  <= ST_DONE;
              busy_r   <= 1'b0;
              finish_r <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_r   <= 1'b0;
            packet_done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign coef_err    = coef_err_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_ch      = out_ch_r;
  assign out_avg     = out_avg_r;
  assign packet_done = packet_done_r;
  assign finish      = finish_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_fir_stream_engine.sv
// Self-checking bench for fir_stream_engine: directed scenarios plus random
// streams compared against a behavioural model of the filter and framing.
module tb_fir_stream_engine;

  localparam int DW = 16, CW = 16, TAPS = 6, CH = 3, SHIFT = 8;
  localparam int PKT_LEN = 12, FRAME_LEN = 24;
  localparam int CHW = 2, AW = 3;

  logic           clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic           start = 1'b0, in_valid = 1'b0, coef_we = 1'b0, out_ready = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic [CHW-1:0] in_ch = '0;
  logic [AW-1:0]  coef_addr = '0;
  logic [CW-1:0]  coef_data = '0;
  logic           in_ready, coef_err, out_valid, packet_done, finish, busy;
  logic [DW-1:0]  out_data, out_avg;
  logic [CHW-1:0] out_ch;

  fir_stream_engine #(
    .DW(DW), .CW(CW), .TAPS(TAPS), .CH(CH), .SHIFT(SHIFT),
    .PKT_LEN(PKT_LEN), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_avg(out_avg), .packet_done(packet_done), .finish(finish), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Behavioural model
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_e;
  mstate_e        m_state;
  longint         m_coef [TAPS];
  longint         m_hist [CH][TAPS];
  int             m_count, m_pkt;
  logic           exp_valid, exp_pkt, exp_finish, exp_ready, obs_ready;
  logic [DW-1:0]  exp_data, exp_avg;
  logic [CHW-1:0] exp_ch;

  task automatic model_clear_lines();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) m_hist[c][k] = 0;
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_count = 0; m_pkt = 0;
    for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
    model_clear_lines();
    exp_valid = 0; exp_pkt = 0; exp_finish = 0; exp_data = 0; exp_avg = 0; exp_ch = 0;
  endtask

  task automatic model_enter_run();
    if (m_state != M_RUN) begin
      m_state = M_RUN; m_count = 0; m_pkt = 0;
      model_clear_lines();
      exp_avg = 0; exp_finish = 0;
    end
  endtask

  function automatic longint model_filter(input longint d, input int ch);
    longint sum;
    if (ch >= CH) return 0;
    for (int k = TAPS - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
    m_hist[ch][0] = d;
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += m_coef[k] * m_hist[ch][k];
    sum = sum >> SHIFT;
    return (sum > 65535) ? 65535 : sum;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0; start = 0; in_valid = 0; coef_we = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic do_coef(input int addr, input int data, input logic with_start,
                         output logic exp_err);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = CW'(data); start = with_start;
    in_valid = 1'b0; out_ready = 1'b1;
    exp_err = (addr >= TAPS) || (m_state == M_RUN);
    if (!exp_err) m_coef[addr] = data;
    if (with_start) model_enter_run();
    exp_valid = 0;
    tick();
    coef_we = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    model_enter_run();
    exp_valid = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic step(input logic v, input int d, input int ch, input logic ordy);
    longint res;
    in_valid = v; in_data = DW'(d); in_ch = CHW'(ch); out_ready = ordy;
    #1;
    obs_ready = in_ready;
    exp_ready = (m_state == M_RUN) && (!exp_valid || ordy);
    if (v && exp_ready) begin
      res = model_filter(d, ch);
      exp_avg = DW'((longint'(exp_avg) + res) >> 1);
      exp_data = DW'(res); exp_ch = CHW'(ch); exp_valid = 1;
      m_count++; m_pkt++;
      exp_pkt = (m_pkt == PKT_LEN);
      if (m_pkt == PKT_LEN) m_pkt = 0;
      if (m_count == FRAME_LEN) begin
        m_state = M_DONE; exp_finish = 1;
      end
    end else if (ordy) begin
      exp_valid = 0;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({out_valid, packet_done, finish, busy, in_ready, coef_err} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {out_valid, packet_done, finish, busy, in_ready, coef_err});
    else passes++;
    checks++; if (out_data !== 16'd0 || out_avg !== 16'd0 || out_ch !== 2'd0)
      $display("FAIL reset_data: got data=%h avg=%h ch=%0d expected zeros", out_data, out_avg, out_ch);
    else passes++;
    tick();
    checks++; if (busy !== 1'b0)
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else passes++;
  endtask

  task automatic test_coef_err_idle();
    logic e;
    do_coef(7, 16'h1234, 1'b0, e);
    checks++; if (coef_err !== e) $display("FAIL coef_addr_err: got %b expected %b", coef_err, e);
    else passes++;
    tick();
    checks++; if (coef_err !== 1'b0) $display("FAIL coef_err_pulse: got %b expected 0", coef_err);
    else passes++;
    do_coef(2, 5, 1'b0, e);
    checks++; if (coef_err !== e) $display("FAIL coef_ok_idle: got %b expected %b", coef_err, e);
    else passes++;
  endtask

  task automatic test_impulse();
    logic e;
    for (int k = 0; k < TAPS; k++) begin
      do_coef(k, (k + 1) << 8, 1'b0, e);
      checks++; if (coef_err !== e) $display("FAIL impulse_coef_load: got %b expected %b", coef_err, e);
      else passes++;
    end
    do_start();
    checks++; if (busy !== 1'b1 || finish !== 1'b0)
      $display("FAIL impulse_start: got busy=%b finish=%b expected 1/0", busy, finish);
    else passes++;
    for (int k = 0; k < TAPS; k++) begin
      step(1'b1, (k == 0) ? 1 : 0, 0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(k + 1))
        $display("FAIL impulse_out: got valid=%b data=%0d expected 1/%0d", out_valid, out_data, k + 1);
      else passes++;
      checks++; if (out_avg !== exp_avg) $display("FAIL impulse_avg: got %0d expected %0d", out_avg, exp_avg);
      else passes++;
    end
  endtask

  task automatic test_coef_in_run();
    logic e;
    do_coef(0, 16'hFFFF, 1'b0, e);
    checks++; if (coef_err !== e) $display("FAIL coef_run_err: got %b expected %b", coef_err, e);
    else passes++;
    step(1'b1, 3, 0, 1'b1);
    checks++; if (out_data !== exp_data) $display("FAIL coef_run_unchanged: got %0d expected %0d", out_data, exp_data);
    else passes++;
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] held;
    step(1'b1, 7, 1, 1'b1);
    held = exp_data;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, int'($urandom_range(0, 65535)), 0, 1'b0);
      checks++; if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
        $display("FAIL stall_hold: got ready=%b valid=%b data=%0d expected 0/1/%0d", obs_ready, out_valid, out_data, held);
      else passes++;
    end
    step(1'b1, 9, 1, 1'b1);
    checks++; if (out_data !== exp_data || out_ch !== 2'd1)
      $display("FAIL stall_release: got data=%0d ch=%0d expected %0d/1", out_data, out_ch, exp_data);
    else passes++;
    do_start();
    step(1'b1, 0, 1, 1'b1);
    checks++; if (busy !== 1'b1 || out_data !== exp_data)
      $display("FAIL start_in_run: got busy=%b data=%0d expected 1/%0d", busy, out_data, exp_data);
    else passes++;
  endtask

  task automatic test_random_frame(input string tag);
    int n = 0;
    while (m_state != M_DONE && n < 400) begin
      step(1'b1 && ($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
      n++;
      checks++; if (obs_ready !== exp_ready || out_valid !== exp_valid || finish !== exp_finish)
        $display("FAIL %s_hs: got ready=%b valid=%b finish=%b expected %b/%b/%b",
                 tag, obs_ready, out_valid, finish, exp_ready, exp_valid, exp_finish);
      else passes++;
      if (exp_valid) begin
        checks++; if (out_data !== exp_data || out_ch !== exp_ch || packet_done !== exp_pkt || out_avg !== exp_avg)
          $display("FAIL %s_out: got data=%0d ch=%0d pkt=%b avg=%0d expected %0d/%0d/%b/%0d",
                   tag, out_data, out_ch, packet_done, out_avg, exp_data, exp_ch, exp_pkt, exp_avg);
        else passes++;
      end
    end
    checks++; if (m_state != M_DONE) $display("FAIL %s_timeout: frame not completed after %0d cycles", tag, n);
    else passes++;
    checks++; if (busy !== 1'b0 || finish !== 1'b1)
      $display("FAIL %s_done: got busy=%b finish=%b expected 0/1", tag, busy, finish);
    else passes++;
    step(1'b1, 5, 0, 1'b1);
    checks++; if (obs_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL %s_done_ready: got ready=%b valid=%b expected 0/0", tag, obs_ready, out_valid);
    else passes++;
  endtask

  task automatic test_channels();
    logic e;
    for (int k = 0; k < TAPS; k++) do_coef(k, 256, 1'b0, e);
    checks++; if (finish !== 1'b1) $display("FAIL finish_level: got %b expected 1", finish);
    else passes++;
    do_start();
    checks++; if (finish !== 1'b0 || busy !== 1'b1 || out_avg !== 16'd0)
      $display("FAIL restart_clear: got finish=%b busy=%b avg=%0d expected 0/1/0", finish, busy, out_avg);
    else passes++;
    for (int r = 0; r < 4; r++) begin
      step(1'b1, 10, 0, 1'b1);
      checks++; if (out_data !== DW'(10 * (r + 1)) || out_ch !== 2'd0)
        $display("FAIL ch0_out: got %0d ch=%0d expected %0d/0", out_data, out_ch, 10 * (r + 1));
      else passes++;
      step(1'b1, 100, 1, 1'b1);
      checks++; if (out_data !== DW'(100 * (r + 1)) || out_ch !== 2'd1)
        $display("FAIL ch1_out: got %0d ch=%0d expected %0d/1", out_data, out_ch, 100 * (r + 1));
      else passes++;
    end
    step(1'b1, 999, 3, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd0 || out_ch !== 2'd3)
      $display("FAIL bad_ch: got valid=%b data=%0d ch=%0d expected 1/0/3", out_valid, out_data, out_ch);
    else passes++;
    step(1'b1, 10, 0, 1'b1);
    checks++; if (out_data !== 16'd50) $display("FAIL ch0_after_bad: got %0d expected 50", out_data);
    else passes++;
    step(1'b1, 100, 1, 1'b1);
    checks++; if (out_data !== 16'd500) $display("FAIL ch1_after_bad: got %0d expected 500", out_data);
    else passes++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'hFFFF, 2, 1'b1);
      checks++; if (out_data !== 16'hFFFF || packet_done !== exp_pkt || out_avg !== exp_avg)
        $display("FAIL saturate: got data=%h pkt=%b avg=%0d expected ffff/%b/%0d", out_data, packet_done, out_avg, exp_pkt, exp_avg);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 3; i++) step(1'b1, int'($urandom_range(1, 65535)), 0, 1'b0);
    Reset_n = 1'b0;
    #2;
    checks++; if ({out_valid, packet_done, finish, busy, in_ready, coef_err} !== 6'b0 ||
                  out_data !== 16'd0 || out_avg !== 16'd0)
      $display("FAIL reset_mid: got flags=%b data=%0d avg=%0d expected zeros",
               {out_valid, packet_done, finish, busy, in_ready, coef_err}, out_data, out_avg);
    else passes++;
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    model_reset();
    do_start();
    step(1'b1, 500, 0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd0)
      $display("FAIL coef_cleared: got valid=%b data=%0d expected 1/0", out_valid, out_data);
    else passes++;
  endtask

  task automatic test_start_with_coef();
    logic e;
    apply_reset();
    do_coef(0, 16'hFFFF, 1'b1, e);
    checks++; if (coef_err !== e || busy !== 1'b1)
      $display("FAIL start_coef: got err=%b busy=%b expected %b/1", coef_err, busy, e);
    else passes++;
    step(1'b1, 16'hFFFF, 0, 1'b1);
    checks++; if (out_data !== 16'hFFFF) $display("FAIL start_coef_sat: got %h expected ffff", out_data);
    else passes++;
    step(1'b1, 1, 0, 1'b1);
    checks++; if (out_data !== 16'h00FF || out_data !== exp_data)
      $display("FAIL start_coef_new: got %h expected 00ff", out_data);
    else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_coef_err_idle();
    test_impulse();
    test_coef_in_run();
    test_back_pressure();
    test_random_frame("frame1");
    test_channels();
    test_saturation();
    test_random_frame("frame2");
    test_reset_mid();
    test_start_with_coef();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
